// File: rtl/fcfs_arbiter_if.sv
// fcfs_arbiter_if: request/grant bundle between requesters and the FCFS arbiter
//  master: drives req, observes grant/grant_valid/grant_id/q_count/timeout
//  slave : the arbiter side of the same signals
interface fcfs_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W:0]    q_count;
  logic             timeout;
  modport master(output req, input grant, grant_valid, grant_id, q_count, timeout);
  modport slave(input req, output grant, grant_valid, grant_id, q_count, timeout);
endinterface

// File: rtl/fcfs_arbiter.sv
// fcfs_arbiter: first-come-first-served arbiter with arrival-ordered ID queue and hold watchdog
//  clk, rst_n (async, active low)
//  bus.req in; bus.grant/grant_valid/grant_id/q_count/timeout out, all registered
module fcfs_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int MAX_HOLD = 16
) (
  input logic           clk,
  input logic           rst_n,
  fcfs_arbiter_if.slave bus
);
  localparam int CW = MAX_HOLD == 0 ? 1 : $clog2(MAX_HOLD + 1);
  typedef enum logic {IDLE, GRANT} state_e;
  state_e state_q, state_d;
  logic [ID_W-1:0] q_q [N_REQ];
  logic [ID_W-1:0] q_d [N_REQ];
  logic [ID_W:0] cnt_q, cnt_d, tail;
  logic [N_REQ-1:0] queued_q, queued_d, lock_q, lock_d, elig, own_vec;
  logic [ID_W-1:0] owner_q, owner_d, head;
  logic [CW-1:0] hold_q, hold_d;
  logic timeout_q, timeout_d, rel, tmo, pop, take;
  always_comb begin
    own_vec = state_q == GRANT ? N_REQ'(1) << owner_q : '0;
    rel = state_q == GRANT && !bus.req[owner_q];
    // release wins over timeout because tmo requires req still high
    tmo = MAX_HOLD != 0 && state_q == GRANT && bus.req[owner_q] && hold_q == CW'(MAX_HOLD);
    pop = cnt_q != '0 && (state_q == IDLE || rel || tmo);
    head = q_q[0];
    // a popped head whose req has dropped is discarded, costing one cycle
    take = pop && bus.req[head];
    state_d = take || (state_q == GRANT && !rel && !tmo) ? GRANT : IDLE;
    owner_d = take ? head : state_d == GRANT ? owner_q : '0;
    hold_d = take ? CW'(1) : state_d == IDLE ? '0 : &hold_q ? hold_q : hold_q + CW'(1);
    timeout_d = tmo;
    lock_d = (lock_q & bus.req) | (tmo ? own_vec : '0);
    elig = bus.req & ~queued_q & ~own_vec & ~lock_q;
    queued_d = (queued_q & ~(pop ? N_REQ'(1) << head : '0)) | elig;
    for (int k = 0; k < N_REQ - 1; k++) q_d[k] = pop ? q_q[k+1] : q_q[k];
    q_d[N_REQ-1] = pop ? '0 : q_q[N_REQ-1];
    // pushes land after the shifted survivors, lowest index first
    tail = cnt_q - (ID_W+1)'(pop);
    for (int i = 0; i < N_REQ; i++)
      if (elig[i]) begin
        q_d[tail[ID_W-1:0]] = ID_W'(i);
        tail = tail + (ID_W+1)'(1);
      end
    cnt_d = tail;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      q_q       <= '{default: '0};
      cnt_q     <= '0;
      queued_q  <= '0;
      lock_q    <= '0;
      owner_q   <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      queued_q  <= queued_d;
      lock_q    <= lock_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  assign bus.grant       = own_vec;
  assign bus.grant_valid = state_q == GRANT;
  assign bus.grant_id    = owner_q;
  assign bus.q_count     = cnt_q;
  assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_fcfs_arbiter.sv
// tb_fcfs_arbiter: directed vector table, hand sequences and random traffic against a queue model
module tb_fcfs_arbiter;
  localparam int N = 4;
  localparam int MH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  fcfs_arbiter_if #(.N_REQ(N), .ID_W(2)) bus();
  fcfs_arbiter #(.N_REQ(N), .ID_W(2), .MAX_HOLD(MH)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int mq[$];
  int mown;
  int mhold;
  bit [N-1:0] mlock;
  bit mto;
  typedef struct {logic [3:0] req; logic [3:0] grant; logic [2:0] qc;} vec_t;
  vec_t tbl [22];
  function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h exp %0h", n, $time, got, exp);
    end
  endfunction
  function automatic void mreset();
    mq.delete();
    mown = -1;
    mhold = 0;
    mlock = '0;
    mto = 1'b0;
  endfunction
  function automatic bit inq(int i);
    foreach (mq[k]) if (mq[k] == i) return 1'b1;
    return 1'b0;
  endfunction
  function automatic void medge(logic [3:0] r);
    bit [N-1:0] push;
    bit rel, tmo;
    int h;
    for (int i = 0; i < N; i++) push[i] = r[i] && !inq(i) && mown != i && !mlock[i];
    rel = mown >= 0 && !r[mown];
    tmo = mown >= 0 && r[mown] && mhold == MH;
    for (int i = 0; i < N; i++) mlock[i] = mlock[i] & r[i];
    if (tmo) mlock[mown] = 1'b1;
    mto = tmo;
    if (mown < 0 || rel || tmo) begin
      mown = -1;
      mhold = 0;
      if (mq.size() > 0) begin
        h = mq.pop_front();
        if (r[h]) begin
          mown = h;
          mhold = 1;
        end
      end
    end else mhold++;
    for (int i = 0; i < N; i++) if (push[i]) mq.push_back(i);
  endfunction
  function automatic void mcheck();
    chk("m_grant", 32'(bus.grant), mown >= 0 ? 32'd1 << mown : 32'd0);
    chk("m_id", 32'(bus.grant_id), mown >= 0 ? mown : 0);
    chk("m_valid", 32'(bus.grant_valid), 32'(mown >= 0));
    chk("m_qcount", 32'(bus.q_count), mq.size());
    chk("m_timeout", 32'(bus.timeout), 32'(mto));
  endfunction
  task automatic step(input logic [3:0] r);
    bus.req = r;
    @(posedge clk);
    medge(r);
    #1;
    mcheck();
  endtask
  initial begin
    int gcyc, tcnt;
    logic [3:0] r;
    tbl = '{
      '{4'b0001, 4'b0000, 3'd1}, '{4'b1001, 4'b0001, 3'd1}, '{4'b1011, 4'b0001, 3'd2},
      '{4'b1011, 4'b0001, 3'd2}, '{4'b1010, 4'b1000, 3'd1}, '{4'b0010, 4'b0010, 3'd0},
      '{4'b0000, 4'b0000, 3'd0},
      '{4'b1111, 4'b0000, 3'd4}, '{4'b1111, 4'b0001, 3'd3}, '{4'b1110, 4'b0010, 3'd2},
      '{4'b1100, 4'b0100, 3'd1}, '{4'b1000, 4'b1000, 3'd0}, '{4'b0000, 4'b0000, 3'd0},
      '{4'b0100, 4'b0000, 3'd1}, '{4'b0100, 4'b0100, 3'd0}, '{4'b0000, 4'b0000, 3'd0},
      '{4'b0001, 4'b0000, 3'd1}, '{4'b0101, 4'b0001, 3'd1}, '{4'b1101, 4'b0001, 3'd2},
      '{4'b1000, 4'b0000, 3'd1}, '{4'b1000, 4'b1000, 3'd0}, '{4'b0000, 4'b0000, 3'd0}
    };
    bus.req = '0;
    mreset();
    #3;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_valid", 32'(bus.grant_valid), 0);
    chk("rst_id", 32'(bus.grant_id), 0);
    chk("rst_qcount", 32'(bus.q_count), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    #9 rst_n = 1'b1;
    foreach (tbl[i]) begin
      step(tbl[i].req);
      chk($sformatf("tbl%0d_grant", i), 32'(bus.grant), 32'(tbl[i].grant));
      chk($sformatf("tbl%0d_qcount", i), 32'(bus.q_count), 32'(tbl[i].qc));
    end
    gcyc = 0;
    tcnt = 0;
    for (int c = 0; c < 40; c++) begin
      step(4'b0010);
      gcyc += int'(bus.grant[1]);
      tcnt += int'(bus.timeout);
    end
    chk("hold_cycles", gcyc, MH);
    chk("timeout_pulses", tcnt, 1);
    step(4'b0000);
    step(4'b0010);
    chk("no_early_regrant", 32'(bus.grant), 0);
    step(4'b0010);
    chk("regrant", 32'(bus.grant), 32'b0010);
    step(4'b0000);
    step(4'b1111);
    step(4'b1111);
    chk("pre_rst_grant", 32'(bus.grant), 32'b0001);
    chk("pre_rst_qcount", 32'(bus.q_count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(bus.grant), 0);
    chk("async_valid", 32'(bus.grant_valid), 0);
    chk("async_id", 32'(bus.grant_id), 0);
    chk("async_qcount", 32'(bus.q_count), 0);
    chk("async_timeout", 32'(bus.timeout), 0);
    mreset();
    #10 rst_n = 1'b1;
    step(4'b1111);
    chk("requeue_qcount", 32'(bus.q_count), 4);
    step(4'b1111);
    chk("requeue_id0", 32'(bus.grant_id), 0);
    step(4'b1110);
    chk("requeue_id1", 32'(bus.grant_id), 1);
    step(4'b1100);
    chk("requeue_id2", 32'(bus.grant_id), 2);
    step(4'b1000);
    chk("requeue_id3", 32'(bus.grant_id), 3);
    r = '0;
    for (int c = 0; c < 500; c++) begin
      r = r ^ 4'($urandom & $urandom & $urandom);
      step(r);
    end
    for (int c = 0; c < 4; c++) step(4'b0000);
    chk("drain_valid", 32'(bus.grant_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
